// File: rtl/spi_slave_tx.sv
// SPI slave transmit datapath: a one-entry holding register fed over valid/ready,
// serialised MSB-first on miso with a programmable bit count per word.
module spi_slave_tx #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [7:0]            counter_in,
  input  logic                  counter_in_upd,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  miso,
  output logic                  tx_done,
  output logic                  underrun
);

  // Largest legal bit-count target; counter_in is clamped to this.
  localparam logic [7:0] MaxTrgt = 8'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [7:0]            counter;
  logic [7:0]            counter_trgt;
  logic                  running;

  logic [7:0] trgt_clamped;
  logic [7:0] eff_trgt;
  logic [7:0] load_shamt;
  logic       word_end;
  logic       load;
  logic       accept;

  // Decode the load/accept conditions and the alignment shift for a new word.
  always_comb begin
    trgt_clamped = (counter_in > MaxTrgt) ? MaxTrgt : counter_in;
    // A target update on the load edge already applies to the word being loaded.
    eff_trgt     = counter_in_upd ? trgt_clamped : counter_trgt;
    load_shamt   = MaxTrgt - eff_trgt;
    word_end     = running && (counter == counter_trgt);
    load         = en && hold_full && (!running || word_end);
    accept       = data_valid && data_ready;
  end

  assign data_ready = rstn && !hold_full;
  assign miso       = shreg[DATA_WIDTH-1];
  assign tx_done    = word_end;

  // Holding register, bit-count target and shifter state.
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      shreg        <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      counter      <= 8'd0;
      counter_trgt <= 8'd7;
      running      <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      // Accept and load are exclusive: accept needs an empty hold, load a full one.
      if (accept) begin
        hold      <= data;
        hold_full <= 1'b1;
      end
      if (counter_in_upd) begin
        counter_trgt <= trgt_clamped;
      end
      if (!en) begin
        // Abort drops the in-flight word but keeps any held word for the next transfer.
        running  <= 1'b0;
        counter  <= 8'd0;
        shreg    <= '0;
        underrun <= 1'b0;
      end else if (load) begin
        shreg     <= hold << load_shamt;
        counter   <= 8'd0;
        running   <= 1'b1;
        hold_full <= 1'b0;
      end else if (running) begin
        shreg <= shreg << 1;
        if (word_end) begin
          running <= 1'b0;
          counter <= 8'd0;
        end else begin
          counter <= counter + 8'd1;
        end
      end else begin
        // Idle, enabled and nothing held: master is clocking with no data available.
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed self-checking bench for spi_slave_tx (DATA_WIDTH = 32).
module tb_spi_slave_tx;

  localparam int unsigned DW = 32;

  logic          sclk = 1'b0;
  logic          rstn;
  logic          en;
  logic [7:0]    counter_in;
  logic          counter_in_upd;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ready;
  logic          miso;
  logic          tx_done;
  logic          underrun;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [63:0] stream;

  spi_slave_tx #(.DATA_WIDTH(DW)) dut (
    .sclk           (sclk),
    .rstn           (rstn),
    .en             (en),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .miso           (miso),
    .tx_done        (tx_done),
    .underrun       (underrun)
  );

  always #5 sclk = ~sclk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; counter_in = 8'd0; counter_in_upd = 1'b0;
    data = '0; data_valid = 1'b0;

    // Reset state.
    tick(); tick();
    chk("rst_miso", miso, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ready_low", data_ready, 1'b0);
    chk("rst_trgt", dut.counter_trgt, 8'd7);
    rstn = 1'b1;
    #1;
    chk("ready_after_rst", data_ready, 1'b1);

    // Single 8-bit word 0xA5.
    data = 32'hA5; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("a5_hold_full", data_ready, 1'b0);
    en = 1'b1;
    tick();
    stream = 64'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_miso_%0d", i), miso, stream[7-i]);
      chk($sformatf("a5_done_%0d", i), tx_done, (i == 7));
      tick();
    end
    chk("a5_idle_running", dut.running, 1'b0);
    chk("a5_idle_miso", miso, 1'b0);
    chk("a5_idle_done", tx_done, 1'b0);
    chk("a5_no_underrun", underrun, 1'b0);

    // Underrun: enabled, idle, nothing held; cleared by one en=0 edge.
    tick();
    chk("underrun_set", underrun, 1'b1);
    chk("underrun_miso", miso, 1'b0);
    en = 1'b0;
    tick();
    chk("underrun_clr", underrun, 1'b0);

    // Two back-to-back 32-bit words, no gap bit.
    counter_in = 8'd31; counter_in_upd = 1'b1;
    data = 32'h8000_0001; data_valid = 1'b1;
    tick();
    counter_in_upd = 1'b0; data_valid = 1'b0;
    chk("trgt_31", dut.counter_trgt, 8'd31);
    en = 1'b1;
    tick();
    data = 32'h7FFF_FFFE; data_valid = 1'b1;
    stream = 64'h8000_0001_7FFF_FFFE;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("b2b_miso_%0d", i), miso, stream[63-i]);
      chk($sformatf("b2b_done_%0d", i), tx_done, (i == 31) || (i == 63));
      tick();
      if (i == 0) data_valid = 1'b0;
    end
    en = 1'b0;
    tick();

    // Hold full while shifting: no overwrite, next word accepted after reload.
    counter_in = 8'd7; counter_in_upd = 1'b1;
    data = 32'h3C; data_valid = 1'b1;
    tick();
    counter_in_upd = 1'b0;
    data = 32'hC3;
    chk("hf_ready_low", data_ready, 1'b0);
    en = 1'b1;
    tick();
    stream = 64'h3C_C3FF;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("hf_miso_%0d", i), miso, stream[23-i]);
      chk($sformatf("hf_done_%0d", i), tx_done, (i == 7) || (i == 15) || (i == 23));
      if (i >= 1 && i <= 7) chk($sformatf("hf_ready_%0d", i), data_ready, 1'b0);
      if (i == 8) chk("hf_ready_after_reload", data_ready, 1'b1);
      tick();
      if (i == 0) data = 32'hFF;
      if (i == 8) data_valid = 1'b0;
    end
    en = 1'b0;
    tick();

    // Abort after 3 bits of 0xFF with 0x0F held; 0x0F is sent next.
    data = 32'hFF; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    en = 1'b1;
    tick();
    chk("ab_bit0", miso, 1'b1);
    data = 32'h0F; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("ab_bit1", miso, 1'b1);
    tick();
    chk("ab_bit2", miso, 1'b1);
    en = 1'b0;
    tick();
    chk("ab_miso", miso, 1'b0);
    chk("ab_counter", dut.counter, 8'd0);
    chk("ab_tx_done", tx_done, 1'b0);
    chk("ab_hold_kept", data_ready, 1'b0);
    en = 1'b1;
    tick();
    stream = 64'h0F;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ab_next_miso_%0d", i), miso, stream[7-i]);
      chk($sformatf("ab_next_done_%0d", i), tx_done, (i == 7));
      tick();
    end
    en = 1'b0;
    tick();

    // Clamp counter_in=40 to 31, then reset mid-word.
    counter_in = 8'd40; counter_in_upd = 1'b1;
    data = 32'hDEAD_BEEF; data_valid = 1'b1;
    tick();
    counter_in_upd = 1'b0; data_valid = 1'b0;
    chk("clamp_trgt", dut.counter_trgt, 8'd31);
    en = 1'b1;
    tick();
    chk("db_bit0", miso, 1'b1);
    tick();
    chk("db_bit1", miso, 1'b1);
    tick();
    chk("db_bit2", miso, 1'b0);
    data = 32'h55; data_valid = 1'b1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready_low", data_ready, 1'b0);
    tick();
    chk("mid_rst_ready_low2", data_ready, 1'b0);
    chk("mid_rst_miso", miso, 1'b0);
    chk("mid_rst_done", tx_done, 1'b0);
    chk("mid_rst_underrun", underrun, 1'b0);
    chk("mid_rst_running", dut.running, 1'b0);
    chk("mid_rst_hold_full", dut.hold_full, 1'b0);
    chk("mid_rst_counter", dut.counter, 8'd0);
    chk("mid_rst_trgt", dut.counter_trgt, 8'd7);
    data_valid = 1'b0; en = 1'b0;
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", data_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
